// File: rtl/riscv_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings,
// FSM state and response error codes.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_t;

  // Stores only exist in byte/half/word flavours; loads add the unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Natural alignment check on the access size held in funct3[1:0].
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane-replicated write data,
// plus extraction and sign/zero extension of load data.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Store side: enables shifted to the addressed lane, data copied to every lane.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures a CPU memory op, runs one valid/ready bus
// transfer with a timeout, and reports completion with an error code.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_done,
  output logic [31:0] load_data,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_off;

  logic [2:0]       al_f3;
  logic [1:0]       al_off;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_ext;

  // One aligner serves both phases: request fields while idle (store
  // formatting), captured fields during the bus cycle (load extension).
  always_comb begin
    al_f3  = cap_f3;
    al_off = cap_off;
    if (state == IDLE) begin
      al_f3  = req_funct3;
      al_off = req_addr[1:0];
    end
  end

  lsu_align u_align (
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_ext)
  );

  // CPU must hold until the op reaches its completion cycle.
  always_comb begin
    stall = req_valid & (state != DONE);
  end

  // Access FSM with capture registers, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_f3    <= '0;
      cap_off   <= '0;
      resp_done <= 1'b0;
      load_data <= '0;
      err_code  <= ERR_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_f3    <= req_funct3;
            cap_off   <= req_addr[1:0];
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= al_wdata;
            mem_be    <= req_we ? al_be : 4'b1111;
            if (!f3_legal(req_we, req_funct3)) begin
              state     <= DONE;
              resp_done <= 1'b1;
              err_code  <= ERR_ILLEGAL;
            end else if (misaligned(req_funct3, req_addr[1:0])) begin
              state     <= DONE;
              resp_done <= 1'b1;
              err_code  <= ERR_MISALIGN;
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
              cnt     <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            state     <= DONE;
            resp_done <= 1'b1;
            err_code  <= ERR_NONE;
            if (!mem_we) load_data <= al_ext;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            state     <= DONE;
            resp_done <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          resp_done <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          resp_done <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed spec scenarios plus randomized
// ops checked against a behavioural reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_done;
  logic [31:0] load_data;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_done(resp_done), .load_data(load_data),
    .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Observations of one op, gathered by run_op.
  int          o_lat, o_stall, o_req;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;
  logic        o_we, o_stable, o_done;
  logic [1:0]  o_err;

  // Drive one op starting just after a rising edge. dly = number of
  // mem_req cycles with mem_ready low before it is raised; -1 = never.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly);
    o_lat = 0; o_stall = 0; o_req = 0; o_done = 1'b0; o_stable = 1'b1;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_ld = '0; o_err = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 60 && !o_done; c++) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (mem_req) begin
        o_req++;
        if (o_req == 1) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
        end else if (o_addr !== mem_addr || o_wdata !== mem_wdata || o_be !== mem_be || o_we !== mem_we) begin
          o_stable = 1'b0;
        end
        mem_ready = (dly >= 0) && (o_req > dly);
        mem_rdata = mem_ready ? rd : $urandom;
      end else begin
        mem_ready = 1'b0;
      end
      if (resp_done) begin
        o_done = 1'b1; o_lat = c; o_ld = load_data; o_err = err_code;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  // Reference model built from the access rules: size/lanes by arithmetic.
  logic [1:0]  m_err;
  logic [3:0]  m_be;
  logic [31:0] m_wd, m_ld;
  int          m_lat, m_req;

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int  size, off;
    bit  legal;
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal)               m_err = 2'd3;
    else if (off % size != 0) m_err = 2'd1;
    else if (dly < 0)         m_err = 2'd2;
    else                      m_err = 2'd0;
    m_be = '0; m_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (!we || (i >= off && i < off + size)) m_be[i] = 1'b1;
      m_wd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    m_ld = rd >> (8 * off);
    if (size == 1) begin
      m_ld = m_ld & 32'hFF;
      if (!f3[2] && m_ld[7]) m_ld = m_ld | 32'hFFFF_FF00;
    end else if (size == 2) begin
      m_ld = m_ld & 32'hFFFF;
      if (!f3[2] && m_ld[15]) m_ld = m_ld | 32'hFFFF_0000;
    end
    if (m_err == 2'd1 || m_err == 2'd3) begin m_lat = 2;  m_req = 0;  end
    else if (m_err == 2'd2)             begin m_lat = 18; m_req = 16; end
    else                                begin m_lat = 3 + dly; m_req = dly + 1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #3;
    n_cmp++;
    if ({mem_req, mem_we, resp_done, stall} !== 4'b0 || load_data !== 32'h0 || err_code !== 2'b00 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: req=%b we=%b done=%b ld=%h err=%b addr=%h wd=%h be=%b (want all zero)",
               mem_req, mem_we, resp_done, load_data, err_code, mem_addr, mem_wdata, mem_be);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_store_word();
    run_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    n_cmp++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_wdata !== 32'hDEAD_BEEF || o_we !== 1'b1) begin
      n_err++;
      $display("FAIL sw_bus: addr=%h be=%b wd=%h we=%b want 00000100 1111 deadbeef 1", o_addr, o_be, o_wdata, o_we);
    end
    n_cmp++;
    if (o_stall != 2 || o_lat != 3 || o_err !== 2'b00) begin
      n_err++;
      $display("FAIL sw_timing: stall=%0d lat=%0d err=%b want 2 3 00", o_stall, o_lat, o_err);
    end
  endtask

  task automatic test_load_ext();
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
    n_cmp++;
    if (o_ld !== 32'hFFFF_FF80 || o_be !== 4'b1111 || o_addr !== 32'h100) begin
      n_err++;
      $display("FAIL lb: ld=%h be=%b addr=%h want ffffff80 1111 00000100", o_ld, o_be, o_addr);
    end
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0);
    n_cmp++;
    if (o_ld !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL lbu: ld=%h want 00000080", o_ld);
    end
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 0);
    n_cmp++;
    if (o_ld !== 32'h0000_80FF) begin
      n_err++;
      $display("FAIL lhu: ld=%h want 000080ff", o_ld);
    end
  endtask

  task automatic test_store_half();
    run_op(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    n_cmp++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_addr !== 32'h200) begin
      n_err++;
      $display("FAIL sh_bus: be=%b wd=%h addr=%h want 1100 abcdabcd 00000200", o_be, o_wdata, o_addr);
    end
  endtask

  task automatic test_faults();
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    n_cmp++;
    if (o_req != 0 || o_lat != 2 || o_err !== 2'b01 || o_stall != 1) begin
      n_err++;
      $display("FAIL misalign: req_cycles=%0d lat=%0d err=%b stall=%0d want 0 2 01 1", o_req, o_lat, o_err, o_stall);
    end
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    n_cmp++;
    if (o_req != 0 || o_lat != 2 || o_err !== 2'b11) begin
      n_err++;
      $display("FAIL illegal: req_cycles=%0d lat=%0d err=%b want 0 2 11", o_req, o_lat, o_err);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1);
    n_cmp++;
    if (o_req != 16 || o_err !== 2'b10 || o_lat != 18 || !o_stable) begin
      n_err++;
      $display("FAIL timeout: req_cycles=%0d err=%b lat=%0d stable=%b want 16 10 18 1", o_req, o_err, o_lat, o_stable);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    saw_done = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_issue: mem_req=%b want 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_drop: mem_req=%b want 0", mem_req);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_done || mem_req) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL rstmid_abandon: resp_done/mem_req seen=1 want 0");
    end
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h1234_5678, 0);
    n_cmp++;
    if (o_ld !== 32'h1234_5678 || o_err !== 2'b00 || o_lat != 3) begin
      n_err++;
      $display("FAIL rstmid_next: ld=%h err=%b lat=%0d want 12345678 00 3", o_ld, o_err, o_lat);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd;
    int          dly;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      model(we, f3, addr, wd, rd, dly);
      run_op(we, f3, addr, wd, rd, dly);
      n_cmp++;
      if (o_err !== m_err || o_lat != m_lat || o_req != m_req || o_stall != m_lat - 1) begin
        n_err++;
        $display("FAIL rand_ctl[%0d]: err=%b lat=%0d req=%0d stall=%0d want %b %0d %0d %0d",
                 n, o_err, o_lat, o_req, o_stall, m_err, m_lat, m_req, m_lat - 1);
      end
      if (m_req > 0) begin
        n_cmp++;
        if (o_addr !== {addr[31:2], 2'b00} || o_be !== m_be || o_we !== we || !o_stable ||
            (we && o_wdata !== m_wd)) begin
          n_err++;
          $display("FAIL rand_bus[%0d]: addr=%h be=%b we=%b wd=%h stable=%b want %h %b %b %h 1",
                   n, o_addr, o_be, o_we, o_wdata, o_stable, {addr[31:2], 2'b00}, m_be, we, m_wd);
        end
      end
      if (!we && m_err == 2'd0) begin
        n_cmp++;
        if (o_ld !== m_ld) begin
          n_err++;
          $display("FAIL rand_load[%0d]: ld=%h want %h (f3=%b addr=%h rd=%h)", n, o_ld, m_ld, f3, addr, rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_store_half();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
